gsensor_sequencer: RTL and testbench

Controller that sequences the 3-wire SPI master for the on-board ADXL345 accelerometer. After enable it verifies the device ID, writes the three configuration registers, then periodically reads the six axis data registers and publishes signed 16-bit X/Y/Z samples. It sits between the SPI master, which executes single-byte register transactions, and the downstream sample consumer in `top`.

---
 rtl/gsensor_sequencer_pkg.sv | 32 +++
 rtl/gsensor_sequencer_xfer_watchdog.sv | 31 +++
 rtl/gsensor_sequencer.sv | 123 ++++++++++++
 tb/tb_gsensor_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gsensor_sequencer_pkg.sv
// gsensor_sequencer_pkg: ADXL345 register map, configuration ROM and sequencer state type
package gsensor_sequencer_pkg;

   typedef enum logic [2:0] {IDLE, ID_RD, CFG_WR, WAIT_TMR, AXIS_RD, PUBLISH, ERROR} seq_states;

   localparam logic [5:0] ADDR_DEVID       = 6'h00;
   localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
   localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
   localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
   localparam logic [5:0] ADDR_DATAX0      = 6'h32;

   localparam logic [7:0] CFG_DATA_FORMAT = 8'h40;
   localparam logic [7:0] CFG_BW_RATE     = 8'h0A;
   localparam logic [7:0] CFG_POWER_CTL   = 8'h08;
   localparam logic [7:0] DEVID           = 8'hE5;

   typedef struct packed {
      logic [5:0] addr;
      logic [7:0] data;
   } cfg_entry_t;

   localparam cfg_entry_t CFG_ROM [3] = '{
      '{ADDR_DATA_FORMAT, CFG_DATA_FORMAT},
      '{ADDR_BW_RATE,     CFG_BW_RATE},
      '{ADDR_POWER_CTL,   CFG_POWER_CTL}
   };

   function automatic logic is_xfer_state(input seq_states s);
      return s inside {ID_RD, CFG_WR, AXIS_RD};
   endfunction

endpackage

// File: rtl/gsensor_sequencer_xfer_watchdog.sv
// gsensor_sequencer_xfer_watchdog: per-transaction timeout counter, armed by start, disarmed by clear
module gsensor_sequencer_xfer_watchdog #(
   parameter int TIMEOUT = 4096
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_start,
   input  logic i_clear,
   output logic o_expire
);

   logic        run;
   logic [31:0] cnt;

   // Count cycles since the request; the request cycle itself is cycle 0
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         run <= 1'b0;
         cnt <= '0;
      end else if (i_clear) begin
         run <= 1'b0;
         cnt <= '0;
      end else if (i_start) begin
         run <= 1'b1;
         cnt <= 32'd1;
      end else if (run)
         cnt <= cnt + 32'd1;

   assign o_expire = run && cnt == 32'(TIMEOUT - 1);

endmodule

// File: rtl/gsensor_sequencer.sv
// gsensor_sequencer: ADXL345 bring-up and periodic X/Y/Z sampling over a single-byte SPI master
module gsensor_sequencer
   import gsensor_sequencer_pkg::*;
#(
   parameter int SAMPLE_PERIOD = 500000,
   parameter int XFER_TIMEOUT  = 4096
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_enb,
   output logic        o_xfer_req,
   output logic        o_xfer_rd,
   output logic [5:0]  o_xfer_addr,
   output logic [7:0]  o_xfer_wdata,
   input  logic        i_xfer_busy,
   input  logic        i_xfer_done,
   input  logic [7:0]  i_xfer_rdata,
   output logic [15:0] o_x,
   output logic [15:0] o_y,
   output logic [15:0] o_z,
   output logic        o_sample_valid,
   output logic        o_init_done,
   output logic        o_error
);

   seq_states   state, state_d;
   logic        wait_ph, wait_ph_d;
   logic [2:0]  idx;
   logic [31:0] timer;
   logic [47:0] cap, cap_d;
   logic        done_ok, expire, last;

   assign done_ok        = wait_ph && i_xfer_done;
   assign last           = state == ID_RD || (state == CFG_WR && idx == 3'd2) || (state == AXIS_RD && idx == 3'd5);
   assign o_sample_valid = state == PUBLISH;
   assign o_error        = state == ERROR;

   gsensor_sequencer_xfer_watchdog #(.TIMEOUT(XFER_TIMEOUT)) u_wdog (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_start  (o_xfer_req),
      .i_clear  (done_ok),
      .o_expire (expire)
   );

   // Transaction fields decode from state and byte index, so they stay put through the wait sub-phase
   always_comb begin
      o_xfer_req   = is_xfer_state(state) && !wait_ph && i_enb && !i_xfer_busy;
      o_xfer_rd    = state == ID_RD || state == AXIS_RD;
      o_xfer_addr  = state == ID_RD   ? ADDR_DEVID :
                     state == CFG_WR  ? CFG_ROM[idx[1:0]].addr :
                     state == AXIS_RD ? ADDR_DATAX0 + {3'b000, idx} : '0;
      o_xfer_wdata = state == CFG_WR ? CFG_ROM[idx[1:0]].data : '0;
   end

   // Next state: enable is only honoured between transactions, done wins over a simultaneous timeout
   always_comb begin
      state_d   = state;
      wait_ph_d = wait_ph;
      case (state)
         IDLE:
            if (i_enb) state_d = o_init_done ? AXIS_RD : ID_RD;
         ID_RD, CFG_WR, AXIS_RD:
            if (!wait_ph) begin
               if (!i_enb) state_d = IDLE;
               else if (!i_xfer_busy) wait_ph_d = 1'b1;
            end else if (i_xfer_done) begin
               wait_ph_d = 1'b0;
               if (state == ID_RD && i_xfer_rdata != DEVID) state_d = ERROR;
               else if (!i_enb) state_d = IDLE;
               else if (last) state_d = state == ID_RD ? CFG_WR : state == CFG_WR ? AXIS_RD : PUBLISH;
            end else if (expire) begin
               wait_ph_d = 1'b0;
               state_d   = ERROR;
            end
         PUBLISH:
            state_d = WAIT_TMR;
         WAIT_TMR:
            if (!i_enb) state_d = IDLE;
            else if (timer == '0) state_d = AXIS_RD;
         ERROR:
            state_d = ERROR;
         default:
            state_d = IDLE;
      endcase
   end

   // Merge the byte arriving now so the sixth byte can be published on the same edge
   always_comb begin
      cap_d = cap;
      if (done_ok && state == AXIS_RD) cap_d[{idx, 3'b000} +: 8] = i_xfer_rdata;
   end

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         state   <= IDLE;
         wait_ph <= 1'b0;
      end else begin
         state   <= state_d;
         wait_ph <= wait_ph_d;
      end

   // Byte index, period timer, capture register and sticky/published outputs
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         idx         <= '0;
         timer       <= '0;
         cap         <= '0;
         o_init_done <= 1'b0;
         o_x         <= '0;
         o_y         <= '0;
         o_z         <= '0;
      end else begin
         idx   <= state_d != state ? '0 : done_ok ? idx + 3'd1 : idx;
         timer <= (state_d == AXIS_RD && state != AXIS_RD) ? 32'(SAMPLE_PERIOD - 1) :
                  (state != IDLE && state != ERROR && timer != '0) ? timer - 32'd1 : timer;
         cap   <= cap_d;
         if (done_ok && state == CFG_WR && idx == 3'd2) o_init_done <= 1'b1;
         if (state_d == PUBLISH) {o_z, o_y, o_x} <= cap_d;
      end

endmodule

// File: tb/tb_gsensor_sequencer.sv
// tb_gsensor_sequencer: scoreboard bench with an SPI master model for gsensor_sequencer
module tb_gsensor_sequencer;

   localparam int P = 200;
   localparam int T = 64;

   logic        clk = 0, rst_n = 0, enb = 0, busy = 0, done = 0;
   logic [7:0]  rdata = 0;
   logic        req, rd, valid, init_done, err;
   logic [5:0]  addr;
   logic [7:0]  wdata;
   logic [15:0] x, y, z;

   gsensor_sequencer #(.SAMPLE_PERIOD(P), .XFER_TIMEOUT(T)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_enb(enb),
      .o_xfer_req(req), .o_xfer_rd(rd), .o_xfer_addr(addr), .o_xfer_wdata(wdata),
      .i_xfer_busy(busy), .i_xfer_done(done), .i_xfer_rdata(rdata),
      .o_x(x), .o_y(y), .o_z(z), .o_sample_valid(valid), .o_init_done(init_done), .o_error(err)
   );

   always #5 clk = ~clk;

   int n_checks = 0, n_pass = 0, n_req = 0, n_valid = 0, cyc = 0, epoch = 0;
   int lat_lo = 3, lat_hi = 3;
   logic withhold = 0;
   logic [7:0] devid_resp = 8'hE5;
   logic [14:0] exp_tx_q[$];
   logic [47:0] exp_s_q[$];
   logic [7:0]  axis_q[$];
   int starts[$], valids[$];
   bit seen[64];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push_init();
      exp_tx_q.push_back({1'b1, 6'h00, 8'h00});
      exp_tx_q.push_back({1'b0, 6'h31, 8'h40});
      exp_tx_q.push_back({1'b0, 6'h2C, 8'h0A});
      exp_tx_q.push_back({1'b0, 6'h2D, 8'h08});
   endtask

   // bytes[8i+:8] is what register 0x32+i returns; X = {DATAX1,DATAX0} etc.
   task automatic push_sample(input logic [47:0] bytes);
      for (int i = 0; i < 6; i++) begin
         axis_q.push_back(bytes[8*i +: 8]);
         exp_tx_q.push_back({1'b1, 6'(6'h32 + i), 8'h00});
      end
      exp_s_q.push_back({bytes[47:40], bytes[39:32], bytes[31:24], bytes[23:16], bytes[15:8], bytes[7:0]});
   endtask

   task automatic push_rand_sample();
      push_sample({$urandom(), 16'($urandom())});
   endtask

   task automatic rst_assert();
      rst_n = 0;
      epoch++;
      #1;
      check("rst_ctrl", {req, rd, addr, wdata, valid, init_done, err}, '0);
      check("rst_data", {x, y, z}, '0);
      repeat (3) @(posedge clk);
      for (int t = 0; busy && t < 100; t++) @(posedge clk);
      exp_tx_q.delete(); exp_s_q.delete(); axis_q.delete();
   endtask

   task automatic rst_release();
      @(posedge clk); #1 rst_n = 1;
   endtask

   task automatic wait_samples(input int n, input int budget);
      for (int t = 0; n_valid < n && t < budget; t++) @(posedge clk);
      check("wait_samples", n_valid >= n, 1);
   endtask

   task automatic wait_seen(input logic [5:0] a, input int budget);
      for (int t = 0; !seen[a] && t < budget; t++) @(posedge clk);
      check("wait_req", seen[a], 1);
   endtask

   task automatic drop_enb();
      #1 enb = 0;
      repeat (5) @(posedge clk);
   endtask

   // SPI master model: latches the request, goes busy, answers after a chosen latency
   initial begin
      logic       m_rd;
      logic [5:0] m_addr;
      logic [7:0] m_wd;
      int         m_lat, ep;
      forever begin
         @(negedge clk);
         if (rst_n && req) begin
            m_rd = rd; m_addr = addr; m_wd = wdata; ep = epoch;
            m_lat = int'($urandom_range(lat_hi, lat_lo));
            @(posedge clk); #1 busy = 1;
            if (withhold) begin
               while (withhold) @(posedge clk);
               #1 busy = 0;
            end else begin
               for (int i = 1; i < m_lat; i++) begin @(posedge clk); #1; end
               done  = 1;
               rdata = !m_rd ? 8'h00 : m_addr == 6'h00 ? devid_resp : axis_q.size() > 0 ? axis_q.pop_front() : 8'($urandom());
               if (ep == epoch && rst_n) check("xfer_hold", {o_rd_q(), addr, wdata}, {m_rd, m_addr, m_wd});
               @(posedge clk); #1 done = 0; busy = 0; rdata = 0;
            end
         end
      end
   end

   function automatic logic o_rd_q();
      return rd;
   endfunction

   // Monitor: every request and every sample pulse is matched against the scoreboard queues
   initial forever begin
      @(negedge clk);
      cyc++;
      if (rst_n && req) begin
         n_req++;
         seen[addr] = 1;
         if (rd && addr == 6'h32) starts.push_back(cyc);
         if (exp_tx_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_req: got rd=%0d addr=%0h wdata=%0h expected none", rd, addr, wdata);
         end else check("xfer_req", {rd, addr, wdata}, exp_tx_q.pop_front());
      end
      if (rst_n && valid) begin
         n_valid++;
         valids.push_back(cyc);
         if (exp_s_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_sample: got %0h expected none", {z, y, x});
         end else check("sample_xyz", {z, y, x}, exp_s_q.pop_front());
      end
   end

   initial begin
      repeat (40000) @(posedge clk);
      $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
      $fatal(1);
   end

   initial begin
      int r0, v0;
      rst_assert();
      rst_release();

      // bring-up with fixed axis bytes
      push_init();
      push_sample(48'h060504030201);
      @(posedge clk); #1 enb = 1;
      @(negedge clk); check("req_not_early", req, 0);
      @(negedge clk); check("req_latency", req, 1);
      wait_samples(1, 500);
      check("init_done", init_done, 1);
      check("x_fixed", x, 16'h0201);
      check("y_fixed", y, 16'h0403);
      check("z_fixed", z, 16'h0605);
      drop_enb();
      check("single_valid", n_valid, 1);
      check("tx_drained", exp_tx_q.size(), 0);

      // fast master, random data and latency: read starts exactly one period apart
      starts.delete(); valids.delete();
      lat_lo = 1; lat_hi = 4;
      repeat (4) push_rand_sample();
      v0 = n_valid;
      @(posedge clk); #1 enb = 1;
      wait_samples(v0 + 4, 1500);
      drop_enb();
      check("starts_count", starts.size(), 4);
      for (int k = 0; k < 3; k++)
         check("period", k + 1 < starts.size() ? starts[k+1] - starts[k] : -1, P);

      // slow master: next read begins two cycles after the sample pulse
      starts.delete(); valids.delete();
      lat_lo = 40; lat_hi = 40;
      repeat (3) push_rand_sample();
      v0 = n_valid;
      @(posedge clk); #1 enb = 1;
      wait_samples(v0 + 3, 2000);
      drop_enb();
      for (int k = 0; k < 2; k++)
         check("slow_restart", k + 1 < starts.size() && k < valids.size() ? starts[k+1] - valids[k] : -1, 2);

      // enable dropped during the third axis read
      lat_lo = 10; lat_hi = 10;
      foreach (seen[i]) seen[i] = 0;
      for (int i = 0; i < 6; i++) axis_q.push_back(8'($urandom()));
      for (int i = 0; i < 3; i++) exp_tx_q.push_back({1'b1, 6'(6'h32 + i), 8'h00});
      @(posedge clk); #1 enb = 1;
      wait_seen(6'h34, 300);
      #1 enb = 0;
      r0 = n_req; v0 = n_valid;
      repeat (40) @(posedge clk);
      check("drop_no_valid", n_valid, v0);
      check("drop_no_req", n_req, r0);
      check("drop_read_done", axis_q.size(), 3);
      check("drop_busy", busy, 0);
      axis_q.delete();
      push_rand_sample();
      @(posedge clk); #1 enb = 1;
      wait_samples(v0 + 1, 500);
      check("reenable_init", init_done, 1);
      drop_enb();

      // reset in the middle of configuration
      rst_assert();
      rst_release();
      lat_lo = 5; lat_hi = 5;
      foreach (seen[i]) seen[i] = 0;
      push_init();
      @(posedge clk); #1 enb = 1;
      wait_seen(6'h2C, 300);
      #1;
      rst_assert();
      push_init();
      push_rand_sample();
      v0 = n_valid;
      rst_release();
      wait_samples(v0 + 1, 600);
      check("rst_restart_init", init_done, 1);
      drop_enb();

      // wrong device ID
      rst_assert();
      devid_resp = 8'hE4;
      exp_tx_q.push_back({1'b1, 6'h00, 8'h00});
      rst_release();
      #1 enb = 1;
      for (int t = 0; !err && t < 100; t++) @(posedge clk);
      check("id_error", err, 1);
      check("id_no_init", init_done, 0);
      r0 = n_req;
      drop_enb();
      #1 enb = 1;
      repeat (30) @(posedge clk);
      check("id_no_more_req", n_req, r0);
      check("id_error_sticky", err, 1);
      #1 enb = 0;

      // withheld done: error exactly 64 cycles after the request
      rst_assert();
      devid_resp = 8'hE5;
      withhold = 1;
      exp_tx_q.push_back({1'b1, 6'h00, 8'h00});
      rst_release();
      foreach (seen[i]) seen[i] = 0;
      #1 enb = 1;
      wait_seen(6'h00, 50);
      repeat (T - 1) @(negedge clk);
      check("timeout_not_early", err, 0);
      @(negedge clk);
      check("timeout_error", err, 1);
      r0 = n_req;
      repeat (20) @(posedge clk);
      check("timeout_no_req", n_req, r0);
      withhold = 0;
      #1 enb = 0;
      rst_assert();
      rst_release();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
